if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS CPU.
- Owns the PC and drives the instruction ROM address; registers the returned word into the IF/ID pipeline register.
- Resolves redirects from later stages and takes interrupt/exception vectors using the kernel-bit-in-PC[31] convention of the CPU.
- Produces EPC for the $26 writeback.

---
 rtl/if_stage.sv | 99 +++++++++
 tb/tb_if_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with PC, redirect/exception/interrupt vectoring and IF/ID register
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h80000000,
  parameter logic [31:0] VEC_TIMER   = 32'h80000004,
  parameter logic [31:0] VEC_EXC     = 32'h80000008,
  parameter logic [31:0] VEC_UART_TX = 32'h8000000C,
  parameter logic [31:0] VEC_UART_RX = 32'h80000010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        irq_timer,
  input  logic        irq_uart_rx,
  input  logic        irq_uart_tx,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] epc_out,
  output logic        epc_we,
  output logic        kernel
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, epc_q, epc_d;
  logic        valid_q, valid_d, epc_we_q, epc_we_d;
  logic [31:0] pc_plus4, irq_vec;
  logic        irq_take;
  // The kernel bit is carried unchanged so sequential fetch never changes mode
  assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
  assign irq_take = !pc_q[31] && (irq_timer || irq_uart_rx || irq_uart_tx);
  assign irq_vec  = irq_timer ? VEC_TIMER : irq_uart_rx ? VEC_UART_RX : VEC_UART_TX;
  // Next PC, IF/ID and EPC selection in priority order exc > redirect > stall > irq > sequential
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    epc_d    = epc_q;
    epc_we_d = 1'b0;
    if (exc_req) begin
      pc_d     = VEC_EXC;
      epc_d    = exc_pc + 32'd4;
      epc_we_d = 1'b1;
      instr_d  = '0;
      valid_d  = 1'b0;
    end else if (redirect) begin
      pc_d    = redirect_pc;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (irq_take) begin
      pc_d     = irq_vec;
      epc_d    = pc_q;
      epc_we_d = 1'b1;
      instr_d  = '0;
      valid_d  = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = rom_data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
    if (flush) begin
      instr_d = '0;
      valid_d = 1'b0;
    end
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      epc_q    <= '0;
      epc_we_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      epc_q    <= epc_d;
      epc_we_q <= epc_we_d;
    end
  end
  assign rom_addr      = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus4 = pc4_q;
  assign ifid_valid    = valid_q;
  assign epc_out       = epc_q;
  assign epc_we        = epc_we_q;
  assign kernel        = pc_q[31];
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage
module tb_if_stage;
  logic        clk = 0, reset = 0, stall = 0, flush = 0, redirect = 0, exc_req = 0;
  logic        irq_timer = 0, irq_uart_rx = 0, irq_uart_tx = 0;
  logic [31:0] redirect_pc = 0, exc_pc = 0, rom_data;
  logic [31:0] rom_addr, ifid_instr, ifid_pc_plus4, epc_out;
  logic        ifid_valid, epc_we, kernel;
  int          checks = 0, errors = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .exc_req(exc_req), .exc_pc(exc_pc), .irq_timer(irq_timer),
    .irq_uart_rx(irq_uart_rx), .irq_uart_tx(irq_uart_tx), .rom_addr(rom_addr),
    .rom_data(rom_data), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .epc_out(epc_out), .epc_we(epc_we), .kernel(kernel)
  );

  always #5 clk = ~clk;
  assign rom_data = (rom_addr == 32'h80000000) ? 32'h08000087 : ~rom_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    step(); step();
    chk("rst_pc", rom_addr, 32'h80000000);
    chk("rst_instr", ifid_instr, 0);
    chk("rst_pc4", ifid_pc_plus4, 0);
    chk("rst_valid", ifid_valid, 0);
    chk("rst_epc", epc_out, 0);
    chk("rst_we", epc_we, 0);
    chk("rst_kernel", kernel, 1);
    reset = 1;
    step();
    chk("w0_instr", ifid_instr, 32'h08000087);
    chk("w0_pc4", ifid_pc_plus4, 32'h80000004);
    chk("w0_valid", ifid_valid, 1);
    chk("w0_pc", rom_addr, 32'h80000004);
    redirect = 1; redirect_pc = 32'h80000014; irq_timer = 1;
    step();
    chk("kr_pc", rom_addr, 32'h80000014);
    chk("kr_valid", ifid_valid, 0);
    redirect = 0;
    step();
    chk("kmask_pc", rom_addr, 32'h80000018);
    chk("kmask_we", epc_we, 0);
    chk("kmask_instr", ifid_instr, 32'h7FFFFFEB);
    chk("kmask_valid", ifid_valid, 1);
    redirect = 1; redirect_pc = 32'h00000250; irq_timer = 0;
    step();
    chk("u250_pc", rom_addr, 32'h00000250);
    chk("u250_kernel", kernel, 0);
    redirect = 0; irq_timer = 1; irq_uart_rx = 1;
    step();
    chk("tmr_pc", rom_addr, 32'h80000004);
    chk("tmr_epc", epc_out, 32'h00000250);
    chk("tmr_we", epc_we, 1);
    chk("tmr_valid", ifid_valid, 0);
    irq_timer = 0; irq_uart_rx = 0;
    step();
    chk("tmr_we_drop", epc_we, 0);
    chk("tmr_epc_hold", epc_out, 32'h00000250);
    chk("tmr_next_pc", rom_addr, 32'h80000008);
    redirect = 1; redirect_pc = 32'h00000260;
    step();
    redirect = 0; irq_uart_rx = 1; irq_uart_tx = 1;
    step();
    chk("rx_pc", rom_addr, 32'h80000010);
    chk("rx_epc", epc_out, 32'h00000260);
    redirect = 1; redirect_pc = 32'h00000270;
    step();
    chk("redir_over_irq_pc", rom_addr, 32'h00000270);
    chk("redir_over_irq_we", epc_we, 0);
    redirect = 0; irq_uart_rx = 0;
    step();
    chk("tx_pc", rom_addr, 32'h8000000C);
    chk("tx_epc", epc_out, 32'h00000270);
    chk("tx_we", epc_we, 1);
    irq_uart_tx = 0; irq_timer = 1;
    step();
    chk("hdl_mask_pc", rom_addr, 32'h80000010);
    chk("hdl_mask_we", epc_we, 0);
    redirect = 1; redirect_pc = 32'h00000254;
    step();
    chk("ret_pc", rom_addr, 32'h00000254);
    chk("ret_we", epc_we, 0);
    redirect = 0;
    step();
    chk("pend_pc", rom_addr, 32'h80000004);
    chk("pend_epc", epc_out, 32'h00000254);
    chk("pend_we", epc_we, 1);
    irq_timer = 0;
    exc_req = 1; exc_pc = 32'h00000300; redirect = 1; redirect_pc = 32'h00000500; stall = 1;
    step();
    chk("exc_pc", rom_addr, 32'h80000008);
    chk("exc_epc", epc_out, 32'h00000304);
    chk("exc_we", epc_we, 1);
    chk("exc_valid", ifid_valid, 0);
    exc_req = 0; redirect = 0; stall = 0;
    step();
    chk("exc_we_drop", epc_we, 0);
    chk("exc_next_pc", rom_addr, 32'h8000000C);
    redirect = 1; redirect_pc = 32'h000000FC;
    step();
    redirect = 0;
    step();
    chk("pre_stall_pc", rom_addr, 32'h00000100);
    chk("pre_stall_instr", ifid_instr, 32'hFFFFFF03);
    stall = 1; irq_timer = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", rom_addr, 32'h00000100);
      chk("stall_instr", ifid_instr, 32'hFFFFFF03);
      chk("stall_pc4", ifid_pc_plus4, 32'h00000100);
      chk("stall_valid", ifid_valid, 1);
      chk("stall_we", epc_we, 0);
    end
    stall = 0; irq_timer = 0;
    step();
    chk("unstall_pc", rom_addr, 32'h00000104);
    chk("unstall_instr", ifid_instr, 32'hFFFFFEFF);
    chk("unstall_pc4", ifid_pc_plus4, 32'h00000104);
    flush = 1;
    step();
    chk("flush_pc", rom_addr, 32'h00000108);
    chk("flush_valid", ifid_valid, 0);
    chk("flush_instr", ifid_instr, 0);
    flush = 0;
    step();
    chk("post_flush_valid", ifid_valid, 1);
    flush = 1; stall = 1;
    step();
    chk("fs_pc", rom_addr, 32'h0000010C);
    chk("fs_valid", ifid_valid, 0);
    chk("fs_instr", ifid_instr, 0);
    flush = 0; stall = 0;
    redirect = 1; redirect_pc = 32'h7FFFFFFC;
    step();
    redirect = 0;
    step();
    chk("wrapu_pc", rom_addr, 32'h00000000);
    chk("wrapu_pc4", ifid_pc_plus4, 32'h00000000);
    chk("wrapu_instr", ifid_instr, 32'h80000003);
    chk("wrapu_kernel", kernel, 0);
    redirect = 1; redirect_pc = 32'hFFFFFFFC;
    step();
    redirect = 0;
    step();
    chk("wrapk_pc", rom_addr, 32'h80000000);
    chk("wrapk_pc4", ifid_pc_plus4, 32'h80000000);
    chk("wrapk_instr", ifid_instr, 32'h00000003);
    chk("wrapk_kernel", kernel, 1);
    reset = 0; redirect = 1; redirect_pc = 32'h00000123; irq_timer = 1;
    step();
    chk("mrst_pc", rom_addr, 32'h80000000);
    chk("mrst_valid", ifid_valid, 0);
    chk("mrst_instr", ifid_instr, 0);
    chk("mrst_epc", epc_out, 0);
    chk("mrst_we", epc_we, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
